// File: rtl/multicycle_controller_pkg.sv
// rtl/multicycle_controller_pkg.sv - shared types and encodings for the multicycle controller
package ctrl_pkg;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        TRAP   = 3'd5
    } stateT;

    typedef enum logic [3:0] {
        CLS_NOP     = 4'd0,
        CLS_J       = 4'd1,
        CLS_JR      = 4'd2,
        CLS_JAL     = 4'd3,
        CLS_BRANCH  = 4'd4,
        CLS_LOAD    = 4'd5,
        CLS_STORE   = 4'd6,
        CLS_ALU     = 4'd7,
        CLS_MOVZ    = 4'd8,
        CLS_ILLEGAL = 4'd9
    } instClassT;

    localparam logic [5:0] OP_RTYPE    = 6'h00;
    localparam logic [5:0] OP_REGIMM   = 6'h01;
    localparam logic [5:0] OP_J        = 6'h02;
    localparam logic [5:0] OP_JAL      = 6'h03;
    localparam logic [5:0] OP_BEQ      = 6'h04;
    localparam logic [5:0] OP_BNE      = 6'h05;
    localparam logic [5:0] OP_BGTZ     = 6'h07;
    localparam logic [5:0] OP_ADDI     = 6'h08;
    localparam logic [5:0] OP_ADDIU    = 6'h09;
    localparam logic [5:0] OP_SLTI     = 6'h0A;
    localparam logic [5:0] OP_ANDI     = 6'h0C;
    localparam logic [5:0] OP_ORI      = 6'h0D;
    localparam logic [5:0] OP_XORI     = 6'h0E;
    localparam logic [5:0] OP_SPECIAL2 = 6'h1C;
    localparam logic [5:0] OP_LW       = 6'h23;
    localparam logic [5:0] OP_SW       = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_MOVZ = 6'h0A;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    localparam logic [5:0] FN2_MUL = 6'h02;
    localparam logic [5:0] FN2_CLZ = 6'h20;
    localparam logic [5:0] FN2_CLO = 6'h21;

    localparam logic [3:0] ALU_AND   = 4'd0;
    localparam logic [3:0] ALU_OR    = 4'd1;
    localparam logic [3:0] ALU_ADD   = 4'd2;
    localparam logic [3:0] ALU_NOR   = 4'd3;
    localparam logic [3:0] ALU_XOR   = 4'd4;
    localparam logic [3:0] ALU_SUB   = 4'd6;
    localparam logic [3:0] ALU_SLT   = 4'd7;
    localparam logic [3:0] ALU_PASSA = 4'd8;
    localparam logic [3:0] ALU_MUL   = 4'd9;
    localparam logic [3:0] ALU_SLL   = 4'd10;
    localparam logic [3:0] ALU_SGT   = 4'd11;
    localparam logic [3:0] ALU_CLZ   = 4'd12;
    localparam logic [3:0] ALU_ROTR  = 4'd13;
    localparam logic [3:0] ALU_SLTU  = 4'd14;

    localparam logic [1:0] PC_SEQ    = 2'd0;
    localparam logic [1:0] PC_BRANCH = 2'd1;
    localparam logic [1:0] PC_JUMP   = 2'd2;
    localparam logic [1:0] PC_REG    = 2'd3;

    localparam logic [1:0] RD_RT = 2'd0;
    localparam logic [1:0] RD_RD = 2'd1;
    localparam logic [1:0] RD_RA = 2'd2;

    localparam logic       ASRC_PC = 1'b0;
    localparam logic       ASRC_RS = 1'b1;

    localparam logic [2:0] BSRC_REG   = 3'd0;
    localparam logic [2:0] BSRC_BOFF  = 3'd1;
    localparam logic [2:0] BSRC_ZERO  = 3'd2;
    localparam logic [2:0] BSRC_IMM   = 3'd3;
    localparam logic [2:0] BSRC_SHAMT = 3'd4;

    localparam logic [2:0] BC_EQ   = 3'b001;
    localparam logic [2:0] BC_NE   = 3'b010;
    localparam logic [2:0] BC_SIGN = 3'b100;

    typedef struct packed {
        instClassT  cls;
        logic [3:0] aluOp;
        logic       aluASrc;
        logic [2:0] aluBSrc;
        logic       extendSign;
        logic [1:0] regDst;
        logic [2:0] branchCond;
        logic       branchNeg;
    } decodeT;

endpackage

// File: rtl/multicycle_controller_if.sv
// rtl/multicycle_controller_if.sv - controller to datapath control/status bundle
interface multicycle_controller_if #(parameter int CNT_W = 32);
    logic [31:0]      Instruction;
    logic             MemReady;
    logic             Zero;
    logic             AluLsb;
    logic             IRWrite;
    logic             PCWrite;
    logic             PCWriteCond;
    logic [1:0]       PCSrc;
    logic [3:0]       ALUControl;
    logic             ALUASrc;
    logic [2:0]       ALUBSrc;
    logic             ExtendSign;
    logic [1:0]       RegDst;
    logic [1:0]       RegDataSel;
    logic             MemtoReg;
    logic             RegWrite;
    logic             MemRead;
    logic             MemWrite;
    logic             IorD;
    logic [2:0]       BranchCond;
    logic [CNT_W-1:0] Retired;
    logic             IllegalOp;
    logic             BusErr;

    modport master (
        input  Instruction, MemReady, Zero, AluLsb,
        output IRWrite, PCWrite, PCWriteCond, PCSrc, ALUControl, ALUASrc, ALUBSrc,
               ExtendSign, RegDst, RegDataSel, MemtoReg, RegWrite, MemRead, MemWrite,
               IorD, BranchCond, Retired, IllegalOp, BusErr
    );

    modport slave (
        output Instruction, MemReady, Zero, AluLsb,
        input  IRWrite, PCWrite, PCWriteCond, PCSrc, ALUControl, ALUASrc, ALUBSrc,
               ExtendSign, RegDst, RegDataSel, MemtoReg, RegWrite, MemRead, MemWrite,
               IorD, BranchCond, Retired, IllegalOp, BusErr
    );
endinterface

// File: rtl/multicycle_controller_instr_decoder.sv
// rtl/multicycle_controller_instr_decoder.sv - IR to instruction class, ALU fields and legality
module instr_decoder
    import ctrl_pkg::*;
#(
    parameter bit EN_SPECIAL2 = 1'b1
) (
    input  logic [31:0] ir,
    output decodeT      dec
);

    logic [5:0] opcode;
    logic [5:0] funct;
    logic [4:0] rt;

    assign opcode = ir[31:26];
    assign funct  = ir[5:0];
    assign rt     = ir[20:16];

    always_comb begin
        dec         = '0;
        dec.cls     = CLS_ILLEGAL;
        dec.aluASrc = ASRC_RS;
        // The all-zero word would otherwise decode as SLL r0,r0,0.
        if (ir == 32'd0) begin
            dec.cls = CLS_NOP;
        end else begin
            case (opcode)
                OP_RTYPE: begin
                    dec.cls    = CLS_ALU;
                    dec.regDst = RD_RD;
                    case (funct)
                        FN_ADD, FN_ADDU: dec.aluOp = ALU_ADD;
                        FN_SUB, FN_SUBU: dec.aluOp = ALU_SUB;
                        FN_AND:          dec.aluOp = ALU_AND;
                        FN_OR:           dec.aluOp = ALU_OR;
                        FN_XOR:          dec.aluOp = ALU_XOR;
                        FN_NOR:          dec.aluOp = ALU_NOR;
                        FN_SLT:          dec.aluOp = ALU_SLT;
                        FN_SLTU:         dec.aluOp = ALU_SLTU;
                        FN_SLLV:         dec.aluOp = ALU_SLL;
                        FN_SLL: begin
                            dec.aluOp   = ALU_SLL;
                            dec.aluBSrc = BSRC_SHAMT;
                        end
                        // Only the rotate forms of SRL/SRLV are supported.
                        FN_SRL: begin
                            dec.aluOp   = ALU_ROTR;
                            dec.aluBSrc = BSRC_SHAMT;
                            if (!ir[21]) dec.cls = CLS_ILLEGAL;
                        end
                        FN_SRLV: begin
                            dec.aluOp = ALU_ROTR;
                            if (!ir[6]) dec.cls = CLS_ILLEGAL;
                        end
                        FN_MOVZ: begin
                            dec.cls   = CLS_MOVZ;
                            dec.aluOp = ALU_PASSA;
                        end
                        FN_JR:   dec.cls = CLS_JR;
                        default: dec.cls = CLS_ILLEGAL;
                    endcase
                end
                OP_REGIMM: begin
                    dec.cls        = CLS_BRANCH;
                    dec.aluOp      = ALU_SLT;
                    dec.aluBSrc    = BSRC_ZERO;
                    dec.branchCond = BC_SIGN;
                    dec.branchNeg  = (rt == 5'd1);
                    if (rt > 5'd1) dec.cls = CLS_ILLEGAL;
                end
                OP_BGTZ: begin
                    dec.cls        = CLS_BRANCH;
                    dec.aluOp      = ALU_SGT;
                    dec.aluBSrc    = BSRC_ZERO;
                    dec.branchCond = BC_SIGN;
                end
                OP_BEQ, OP_BNE: begin
                    dec.cls        = CLS_BRANCH;
                    dec.aluOp      = ALU_SUB;
                    dec.branchCond = (opcode == OP_BEQ) ? BC_EQ : BC_NE;
                end
                OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI: begin
                    dec.cls        = CLS_ALU;
                    dec.aluBSrc    = BSRC_IMM;
                    dec.extendSign = (opcode == OP_ADDI) || (opcode == OP_SLTI);
                    case (opcode)
                        OP_SLTI: dec.aluOp = ALU_SLT;
                        OP_ANDI: dec.aluOp = ALU_AND;
                        OP_ORI:  dec.aluOp = ALU_OR;
                        OP_XORI: dec.aluOp = ALU_XOR;
                        default: dec.aluOp = ALU_ADD;
                    endcase
                end
                OP_SPECIAL2: begin
                    dec.regDst = RD_RD;
                    if (EN_SPECIAL2) begin
                        dec.cls = CLS_ALU;
                        case (funct)
                            FN2_CLZ, FN2_CLO: dec.aluOp = ALU_CLZ;
                            FN2_MUL:          dec.aluOp = ALU_MUL;
                            default:          dec.cls   = CLS_ILLEGAL;
                        endcase
                    end
                end
                OP_LW, OP_SW: begin
                    dec.cls        = (opcode == OP_LW) ? CLS_LOAD : CLS_STORE;
                    dec.aluOp      = ALU_ADD;
                    dec.aluBSrc    = BSRC_IMM;
                    dec.extendSign = 1'b1;
                end
                OP_J:   dec.cls = CLS_J;
                OP_JAL: begin
                    dec.cls    = CLS_JAL;
                    dec.regDst = RD_RA;
                end
                default: dec.cls = CLS_ILLEGAL;
            endcase
        end
    end

endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multicycle FSM sequencing fetch/decode/exec/mem/wb with traps
module multicycle_controller
    import ctrl_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 15,
    parameter bit EN_SPECIAL2 = 1'b1
) (
    input logic                     Clk,
    input logic                     Reset,
    multicycle_controller_if.master bus
);

    stateT            state;
    stateT            stateNext;
    logic [31:0]      ir;
    logic [7:0]       waitCnt;
    logic [7:0]       waitNext;
    logic [CNT_W-1:0] retiredQ;
    logic             illegalQ;
    logic             busErrQ;
    logic             retire;
    logic             setIllegal;
    logic             setBusErr;
    logic             irLoad;
    logic             driveAlu;
    logic             memTimeout;
    logic             branchTaken;
    decodeT           dec;

    instr_decoder #(.EN_SPECIAL2(EN_SPECIAL2)) uDecoder (
        .ir  (ir),
        .dec (dec)
    );

    assign waitNext    = waitCnt + 8'd1;
    // A ready in the final allowed cycle completes the access rather than trapping.
    assign memTimeout  = !bus.MemReady && (waitNext == 8'(MEM_TIMEOUT));
    assign branchTaken = (dec.branchCond[0] & bus.Zero)
                       | (dec.branchCond[1] & ~bus.Zero)
                       | (dec.branchCond[2] & (bus.AluLsb ^ dec.branchNeg));

    assign bus.Retired   = retiredQ;
    assign bus.IllegalOp = illegalQ;
    assign bus.BusErr    = busErrQ;

    always_comb begin
        stateNext       = state;
        retire          = 1'b0;
        setIllegal      = 1'b0;
        setBusErr       = 1'b0;
        irLoad          = 1'b0;
        driveAlu        = 1'b0;
        bus.IRWrite     = 1'b0;
        bus.PCWrite     = 1'b0;
        bus.PCWriteCond = 1'b0;
        bus.PCSrc       = PC_SEQ;
        bus.ALUControl  = 4'd0;
        bus.ALUASrc     = 1'b0;
        bus.ALUBSrc     = 3'd0;
        bus.ExtendSign  = 1'b0;
        bus.RegDst      = RD_RT;
        bus.RegDataSel  = 2'd0;
        bus.MemtoReg    = 1'b0;
        bus.RegWrite    = 1'b0;
        bus.MemRead     = 1'b0;
        bus.MemWrite    = 1'b0;
        bus.IorD        = 1'b0;
        bus.BranchCond  = 3'd0;

        case (state)
            FETCH: begin
                bus.MemRead = 1'b1;
                if (bus.MemReady) begin
                    irLoad      = 1'b1;
                    bus.PCWrite = 1'b1;
                    stateNext   = DECODE;
                end else if (memTimeout) begin
                    setBusErr = 1'b1;
                    stateNext = TRAP;
                end
            end
            DECODE: begin
                bus.ALUASrc    = ASRC_PC;
                bus.ALUBSrc    = BSRC_BOFF;
                bus.ExtendSign = 1'b1;
                bus.ALUControl = ALU_ADD;
                case (dec.cls)
                    CLS_NOP: begin
                        retire    = 1'b1;
                        stateNext = FETCH;
                    end
                    CLS_J, CLS_JR: begin
                        retire      = 1'b1;
                        bus.PCWrite = 1'b1;
                        bus.PCSrc   = (dec.cls == CLS_J) ? PC_JUMP : PC_REG;
                        stateNext   = FETCH;
                    end
                    CLS_JAL: begin
                        bus.PCWrite = 1'b1;
                        bus.PCSrc   = PC_JUMP;
                        stateNext   = WB;
                    end
                    CLS_ILLEGAL: begin
                        setIllegal = 1'b1;
                        stateNext  = TRAP;
                    end
                    default: stateNext = EXEC;
                endcase
            end
            EXEC: begin
                driveAlu = 1'b1;
                case (dec.cls)
                    CLS_BRANCH: begin
                        bus.PCWriteCond = branchTaken;
                        bus.PCSrc       = PC_BRANCH;
                        bus.BranchCond  = dec.branchCond;
                        retire          = 1'b1;
                        stateNext       = FETCH;
                    end
                    CLS_LOAD, CLS_STORE: stateNext = MEM;
                    default:             stateNext = WB;
                endcase
            end
            MEM: begin
                driveAlu     = 1'b1;
                bus.IorD     = 1'b1;
                bus.MemRead  = (dec.cls == CLS_LOAD);
                bus.MemWrite = (dec.cls == CLS_STORE);
                if (bus.MemReady) begin
                    if (dec.cls == CLS_STORE) begin
                        retire    = 1'b1;
                        stateNext = FETCH;
                    end else begin
                        stateNext = WB;
                    end
                end else if (memTimeout) begin
                    setBusErr = 1'b1;
                    stateNext = TRAP;
                end
            end
            WB: begin
                // ALU fields stay driven so MOVZ sees its rt==0 test on Zero.
                driveAlu       = (dec.cls != CLS_JAL);
                bus.RegWrite   = (dec.cls == CLS_MOVZ) ? bus.Zero : 1'b1;
                bus.RegDst     = dec.regDst;
                bus.MemtoReg   = (dec.cls == CLS_LOAD);
                bus.RegDataSel = (dec.cls == CLS_JAL) ? 2'd1 : 2'd0;
                retire         = 1'b1;
                stateNext      = FETCH;
            end
            default: stateNext = TRAP;
        endcase

        if (driveAlu) begin
            bus.ALUControl = dec.aluOp;
            bus.ALUASrc    = dec.aluASrc;
            bus.ALUBSrc    = dec.aluBSrc;
            bus.ExtendSign = dec.extendSign;
        end
        bus.IRWrite = irLoad;

        if (Reset) begin
            bus.IRWrite     = 1'b0;
            bus.PCWrite     = 1'b0;
            bus.PCWriteCond = 1'b0;
            bus.PCSrc       = PC_SEQ;
            bus.ALUControl  = 4'd0;
            bus.ALUASrc     = 1'b0;
            bus.ALUBSrc     = 3'd0;
            bus.ExtendSign  = 1'b0;
            bus.RegDst      = RD_RT;
            bus.RegDataSel  = 2'd0;
            bus.MemtoReg    = 1'b0;
            bus.RegWrite    = 1'b0;
            bus.MemRead     = 1'b0;
            bus.MemWrite    = 1'b0;
            bus.IorD        = 1'b0;
            bus.BranchCond  = 3'd0;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state    <= FETCH;
            ir       <= 32'd0;
            waitCnt  <= 8'd0;
            retiredQ <= '0;
            illegalQ <= 1'b0;
            busErrQ  <= 1'b0;
        end else begin
            state <= stateNext;
            if (irLoad) ir <= bus.Instruction;
            if (stateNext != state) begin
                waitCnt <= 8'd0;
            end else if ((state == FETCH || state == MEM) && !bus.MemReady) begin
                waitCnt <= waitNext;
            end
            if (retire)     retiredQ <= retiredQ + CNT_W'(1);
            if (setIllegal) illegalQ <= 1'b1;
            if (setBusErr)  busErrQ  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - directed self-checking bench for multicycle_controller
module tb_multicycle_controller;

    logic Clk;
    logic Reset;
    logic Reset2;
    int   errors = 0;
    int   checks = 0;

    multicycle_controller_if #(.CNT_W(32)) bus ();
    multicycle_controller_if #(.CNT_W(4))  bus4 ();

    multicycle_controller #(.CNT_W(32), .MEM_TIMEOUT(15), .EN_SPECIAL2(1'b1)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    multicycle_controller #(.CNT_W(4), .MEM_TIMEOUT(15), .EN_SPECIAL2(1'b0)) dut4 (
        .Clk   (Clk),
        .Reset (Reset2),
        .bus   (bus4)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        Reset = 1'b1;
        Reset2 = 1'b1;
        bus.Instruction = 32'h0000_0000;
        bus.MemReady = 1'b0;
        bus.Zero = 1'b0;
        bus.AluLsb = 1'b0;
        bus4.Instruction = 32'h0000_0000;
        bus4.MemReady = 1'b0;
        bus4.Zero = 1'b0;
        bus4.AluLsb = 1'b0;
        #1;
        chk("rst_memread", bus.MemRead, 1'b0);
        chk("rst_retired", bus.Retired, 32'd0);
        chk("rst_illegal", bus.IllegalOp, 1'b0);
        chk("rst_buserr", bus.BusErr, 1'b0);
        tick();
        tick();

        // ADD r3,r1,r2 with zero-wait memory
        bus.Instruction = 32'h0022_1820;
        bus.MemReady = 1'b1;
        Reset = 1'b0;
        #1;
        chk("add_fetch_memread", bus.MemRead, 1'b1);
        chk("add_fetch_irwrite", bus.IRWrite, 1'b1);
        chk("add_fetch_pcwrite", bus.PCWrite, 1'b1);
        tick();
        chk("add_decode_bsrc", bus.ALUBSrc, 3'd1);
        chk("add_decode_sext", bus.ExtendSign, 1'b1);
        tick();
        chk("add_exec_aluop", bus.ALUControl, 4'd2);
        chk("add_exec_regwrite", bus.RegWrite, 1'b0);
        tick();
        chk("add_wb_regwrite", bus.RegWrite, 1'b1);
        chk("add_wb_regdst", bus.RegDst, 2'd1);
        chk("add_wb_aluop", bus.ALUControl, 4'd2);
        chk("add_wb_retired", bus.Retired, 32'd0);
        tick();
        chk("add_next_fetch", bus.MemRead & ~bus.IorD, 1'b1);
        chk("add_retired", bus.Retired, 32'd1);

        // LW with three MEM wait cycles: 8 cycles in total
        bus.Instruction = 32'h8C22_0004;
        tick();
        tick();
        bus.MemReady = 1'b0;
        tick();
        chk("lw_mem1_memread", bus.MemRead, 1'b1);
        chk("lw_mem1_iord", bus.IorD, 1'b1);
        tick();
        chk("lw_mem2_memread", bus.MemRead, 1'b1);
        tick();
        chk("lw_mem3_memread", bus.MemRead, 1'b1);
        chk("lw_mem3_memwrite", bus.MemWrite, 1'b0);
        tick();
        bus.MemReady = 1'b1;
        #1;
        chk("lw_mem4_memread", bus.MemRead, 1'b1);
        tick();
        chk("lw_wb_memtoreg", bus.MemtoReg, 1'b1);
        chk("lw_wb_regwrite", bus.RegWrite, 1'b1);
        chk("lw_wb_regdst", bus.RegDst, 2'd0);
        chk("lw_wb_memread", bus.MemRead, 1'b0);
        tick();
        chk("lw_next_fetch", bus.MemRead & ~bus.IorD, 1'b1);
        chk("lw_retired", bus.Retired, 32'd2);

        // BEQ taken on Zero=1
        bus.Instruction = 32'h1022_0003;
        bus.Zero = 1'b1;
        tick();
        tick();
        chk("beq_pcwritecond", bus.PCWriteCond, 1'b1);
        chk("beq_branchcond", bus.BranchCond, 3'b001);
        chk("beq_pcsrc", bus.PCSrc, 2'd1);
        chk("beq_aluop", bus.ALUControl, 4'd6);
        tick();
        chk("beq_next_fetch", bus.MemRead & ~bus.IorD, 1'b1);
        chk("beq_retired", bus.Retired, 32'd3);

        // BNE not taken on Zero=1, taken once Zero drops
        bus.Instruction = 32'h1422_0003;
        tick();
        tick();
        chk("bne_pcwritecond_z1", bus.PCWriteCond, 1'b0);
        chk("bne_branchcond", bus.BranchCond, 3'b010);
        bus.Zero = 1'b0;
        #1;
        chk("bne_pcwritecond_z0", bus.PCWriteCond, 1'b1);
        tick();
        chk("bne_next_fetch", bus.MemRead & ~bus.IorD, 1'b1);
        chk("bne_retired", bus.Retired, 32'd4);

        // MOVZ r3,r1,r2 with Zero=0 suppresses the write
        bus.Instruction = 32'h0022_180A;
        tick();
        tick();
        tick();
        chk("movz_wb_regwrite_z0", bus.RegWrite, 1'b0);
        chk("movz_wb_regdst", bus.RegDst, 2'd1);
        bus.Zero = 1'b1;
        #1;
        chk("movz_wb_regwrite_z1", bus.RegWrite, 1'b1);
        bus.Zero = 1'b0;
        tick();
        chk("movz_retired", bus.Retired, 32'd5);

        // BGEZ: taken when the SLT-against-zero bit is clear
        bus.Instruction = 32'h0421_0002;
        bus.AluLsb = 1'b0;
        tick();
        tick();
        chk("bgez_aluop", bus.ALUControl, 4'd7);
        chk("bgez_bsrc", bus.ALUBSrc, 3'd2);
        chk("bgez_branchcond", bus.BranchCond, 3'b100);
        chk("bgez_taken", bus.PCWriteCond, 1'b1);
        bus.AluLsb = 1'b1;
        #1;
        chk("bgez_not_taken", bus.PCWriteCond, 1'b0);
        tick();
        chk("bgez_retired", bus.Retired, 32'd6);

        // J: two cycles
        bus.Instruction = 32'h0800_0010;
        tick();
        chk("j_pcwrite", bus.PCWrite, 1'b1);
        chk("j_pcsrc", bus.PCSrc, 2'd2);
        tick();
        chk("j_next_fetch", bus.MemRead & ~bus.IorD, 1'b1);
        chk("j_retired", bus.Retired, 32'd7);

        // JAL: link write in WB
        bus.Instruction = 32'h0C00_0010;
        tick();
        chk("jal_pcwrite", bus.PCWrite, 1'b1);
        chk("jal_pcsrc", bus.PCSrc, 2'd2);
        tick();
        chk("jal_wb_regdst", bus.RegDst, 2'd2);
        chk("jal_wb_regdatasel", bus.RegDataSel, 2'd1);
        chk("jal_wb_regwrite", bus.RegWrite, 1'b1);
        tick();
        chk("jal_retired", bus.Retired, 32'd8);

        // MUL r3,r1,r2 decodes when SPECIAL2 is enabled
        bus.Instruction = 32'h7022_1802;
        tick();
        tick();
        chk("mul_aluop", bus.ALUControl, 4'd9);
        tick();
        chk("mul_wb_regwrite", bus.RegWrite, 1'b1);
        tick();
        chk("mul_retired", bus.Retired, 32'd9);

        // SW with ready memory
        bus.Instruction = 32'hAC22_0004;
        tick();
        tick();
        chk("sw_exec_aluop", bus.ALUControl, 4'd2);
        tick();
        chk("sw_mem_memwrite", bus.MemWrite, 1'b1);
        chk("sw_mem_memread", bus.MemRead, 1'b0);
        chk("sw_mem_iord", bus.IorD, 1'b1);
        tick();
        chk("sw_next_fetch", bus.MemRead & ~bus.IorD, 1'b1);
        chk("sw_retired", bus.Retired, 32'd10);

        // Second SW aborted by reset mid-MEM
        tick();
        tick();
        bus.MemReady = 1'b0;
        tick();
        chk("sw2_mem_memwrite", bus.MemWrite, 1'b1);
        Reset = 1'b1;
        #1;
        chk("sw2_rst_memwrite", bus.MemWrite, 1'b0);
        chk("sw2_rst_retired", bus.Retired, 32'd0);
        tick();
        Reset = 1'b0;
        bus.MemReady = 1'b1;
        bus.Instruction = 32'hFC00_0000;
        #1;
        chk("after_rst_fetch", bus.MemRead & ~bus.IorD, 1'b1);

        // Opcode 0x3F traps after DECODE
        tick();
        chk("ill_decode_flag", bus.IllegalOp, 1'b0);
        tick();
        chk("ill_trap_flag", bus.IllegalOp, 1'b1);
        chk("ill_trap_memread", bus.MemRead, 1'b0);
        tick();
        tick();
        chk("ill_hold_memread", bus.MemRead, 1'b0);
        chk("ill_hold_pcwrite", bus.PCWrite, 1'b0);
        chk("ill_hold_irwrite", bus.IRWrite, 1'b0);
        chk("ill_hold_flag", bus.IllegalOp, 1'b1);
        chk("ill_hold_retired", bus.Retired, 32'd0);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        bus.MemReady = 1'b0;
        #1;
        chk("ill_rst_flag", bus.IllegalOp, 1'b0);
        chk("ill_rst_fetch", bus.MemRead, 1'b1);

        // FETCH starved for 15 cycles
        repeat (14) tick();
        chk("to_cycle15_memread", bus.MemRead, 1'b1);
        chk("to_cycle15_buserr", bus.BusErr, 1'b0);
        tick();
        chk("to_buserr", bus.BusErr, 1'b1);
        chk("to_trap_memread", bus.MemRead, 1'b0);

        // Ready on the 15th cycle completes instead of trapping
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        bus.Instruction = 32'h0000_0000;
        #1;
        chk("edge_rst_buserr", bus.BusErr, 1'b0);
        repeat (14) tick();
        bus.MemReady = 1'b1;
        #1;
        chk("edge_irwrite", bus.IRWrite, 1'b1);
        tick();
        chk("edge_decode_buserr", bus.BusErr, 1'b0);
        chk("edge_decode_memread", bus.MemRead, 1'b0);
        tick();
        chk("edge_nop_retired", bus.Retired, 32'd1);
        chk("edge_next_fetch", bus.MemRead, 1'b1);

        // Narrow counter wraps after 16 NOPs
        Reset = 1'b1;
        bus4.MemReady = 1'b1;
        bus4.Instruction = 32'h0000_0000;
        #1;
        chk("w4_rst_retired", bus4.Retired, 32'd0);
        tick();
        Reset2 = 1'b0;
        repeat (30) tick();
        chk("w4_retired15", bus4.Retired, 32'd15);
        repeat (2) tick();
        chk("w4_retired_wrap", bus4.Retired, 32'd0);

        // Opcode 28 traps when SPECIAL2 is disabled
        bus4.Instruction = 32'h7022_1802;
        tick();
        tick();
        chk("w4_special2_illegal", bus4.IllegalOp, 1'b1);
        chk("w4_special2_memread", bus4.MemRead, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
